atmega_eep_prog: RTL and testbench

ATMEGA_EEP_PROG -- requirements
Module: atmega_eep_prog

---
 rtl/atmega_eep_pkg.sv | 24 ++
 rtl/eep_ram.sv | 21 ++
 rtl/atmega_eep_prog.sv | 215 +++++++++++++++++++++
 tb/tb_atmega_eep_prog.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/atmega_eep_pkg.sv
// Shared constants for the EEPROM controller: EECR bit positions,
// programming-mode encodings and controller state encodings.
package atmega_eep_pkg;

   localparam int EERE_BIT  = 0;
   localparam int EEPE_BIT  = 1;
   localparam int EEMPE_BIT = 2;
   localparam int EERIE_BIT = 3;
   localparam int EEPM_LSB  = 4;

   typedef enum logic [1:0] {
      EEPM_ERASE_WRITE = 2'b00,
      EEPM_ERASE_ONLY  = 2'b01,
      EEPM_WRITE_ONLY  = 2'b10,
      EEPM_RESERVED    = 2'b11
   } eepm_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_ERASE = 2'b01,
      ST_WRITE = 2'b10
   } eep_state_t;

endpackage

// File: rtl/eep_ram.sv
// Single-port byte array with registered read-first output; contents start
// erased (all 8'hFF) and are never touched by reset.
module eep_ram #(
   parameter int DEPTH = 1024,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic [AW-1:0] addr,
   input  logic          we,
   input  logic [7:0]    wdata,
   output logic [7:0]    rdata
);

   logic [7:0] mem [DEPTH] = '{default: 8'hFF};

   always_ff @(posedge clk) begin
      if (we) mem[addr] <= wdata;
      rdata <= mem[addr];
   end

endmodule

// File: rtl/atmega_eep_prog.sv
// AVR-style EEPROM controller: EEAR/EEDR/EECR register file, timed erase/write
// sequencer, EE-ready interrupt and an external programmer port.
// The interrupt output is named eep_int because "int" is a reserved word.
module atmega_eep_prog
   import atmega_eep_pkg::*;
#(
   parameter int                           BUS_ADDR_DATA_LEN = 8,
   parameter logic [BUS_ADDR_DATA_LEN-1:0] EEARH_ADDR        = 'h20,
   parameter logic [BUS_ADDR_DATA_LEN-1:0] EEARL_ADDR        = 'h21,
   parameter logic [BUS_ADDR_DATA_LEN-1:0] EEDR_ADDR         = 'h22,
   parameter logic [BUS_ADDR_DATA_LEN-1:0] EECR_ADDR         = 'h23,
   parameter int                           EEP_SIZE          = 1024,
   parameter int                           PROG_CYCLES       = 16,
   parameter int                           MPE_WINDOW        = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [BUS_ADDR_DATA_LEN-1:0] addr,
   input  logic                         wr,
   input  logic                         rd,
   input  logic [7:0]                   bus_in,
   output logic [7:0]                   bus_out,
   output logic                         eep_int,
   input  logic                         int_rst,
   input  logic [16:0]                  ext_eep_addr,
   input  logic [7:0]                   ext_eep_data_in,
   input  logic                         ext_eep_data_wr,
   output logic [7:0]                   ext_eep_data_out,
   input  logic                         ext_eep_data_rd,
   input  logic                         ext_eep_data_en,
   output logic                         busy,
   output logic                         content_modifyed,
   output eep_state_t                   state_dbg
);

   localparam int AW = $clog2(EEP_SIZE);
   localparam int CW = (PROG_CYCLES > 1) ? $clog2(PROG_CYCLES) : 1;
   localparam int MW = $clog2(MPE_WINDOW + 1);

   logic [7:0]    eearh, eearl, eedr;
   logic          eere, eerie, eepe_rsv, busy_q;
   eepm_t         eepm, prog_mode;
   logic [MW-1:0] mpe_cnt;
   eep_state_t    state;
   logic [CW-1:0] cnt;
   logic [AW-1:0] prog_addr;
   logic [7:0]    prog_data;
   logic          rdy_flag, modified, cpu_rd_phase, ext_rd_q;

   logic [15:0]   eear;
   logic [7:0]    eecr;
   logic          wr_eecr, mpe_armed, start, last_clk, ext_active;
   logic [AW-1:0] ram_addr;
   logic          ram_we;
   logic [7:0]    ram_wdata, ram_rdata;
   logic          unused_bits;

   assign eear       = {eearh, eearl};
   assign eecr       = {2'b00, eepm, eerie, mpe_armed, busy_q | eepe_rsv, eere};
   assign wr_eecr    = wr && (addr == EECR_ADDR);
   assign mpe_armed  = (mpe_cnt != '0);
   assign start      = wr_eecr && bus_in[EEPE_BIT] && mpe_armed && !busy_q && !ext_eep_data_en;
   assign ext_active = ext_eep_data_en && !busy_q;
   assign unused_bits = ^{ext_eep_addr, eear};

   // The array is written only in the final clock of the final phase.
   assign last_clk = busy_q && (cnt == '0) &&
                     ((state == ST_WRITE) || (state == ST_ERASE && prog_mode == EEPM_ERASE_ONLY));

   // Array port arbitration: programming sequencer, then CPU read, then programmer.
   always_comb begin
      ram_addr  = ext_eep_addr[AW-1:0];
      ram_we    = 1'b0;
      ram_wdata = ext_eep_data_in;
      if (busy_q) begin
         ram_addr = prog_addr;
         ram_we   = last_clk;
         case (prog_mode)
            EEPM_ERASE_WRITE: ram_wdata = prog_data;
            EEPM_WRITE_ONLY:  ram_wdata = ram_rdata & prog_data;
            default:          ram_wdata = 8'hFF;
         endcase
      end else if (eere) begin
         ram_addr = eear[AW-1:0];
      end else if (ext_active) begin
         ram_we = ext_eep_data_wr;
      end
      if (rst) ram_we = 1'b0;
   end

   eep_ram #(.DEPTH(EEP_SIZE), .AW(AW)) u_ram (
      .clk   (clk),
      .addr  (ram_addr),
      .we    (ram_we),
      .wdata (ram_wdata),
      .rdata (ram_rdata)
   );

   always_comb begin
      bus_out = 8'h00;
      if (rd) begin
         if      (addr == EEARH_ADDR) bus_out = eearh;
         else if (addr == EEARL_ADDR) bus_out = eearl;
         else if (addr == EEDR_ADDR)  bus_out = eedr;
         else if (addr == EECR_ADDR)  bus_out = eecr;
      end
   end

   assign eep_int          = eerie & rdy_flag;
   assign ext_eep_data_out = ext_rd_q ? ram_rdata : 8'h00;
   assign busy             = busy_q;
   assign content_modifyed = modified;
   assign state_dbg        = state;

   always_ff @(posedge clk) begin
      if (rst) begin
         eearh        <= 8'h00;
         eearl        <= 8'h00;
         eedr         <= 8'h00;
         eere         <= 1'b0;
         eerie        <= 1'b0;
         eepe_rsv     <= 1'b0;
         eepm         <= EEPM_ERASE_WRITE;
         mpe_cnt      <= '0;
         state        <= ST_IDLE;
         cnt          <= '0;
         busy_q       <= 1'b0;
         prog_addr    <= '0;
         prog_data    <= 8'h00;
         prog_mode    <= EEPM_ERASE_WRITE;
         rdy_flag     <= 1'b0;
         modified     <= 1'b0;
         cpu_rd_phase <= 1'b0;
         ext_rd_q     <= 1'b0;
      end else begin
         if (!busy_q) begin
            if (wr && addr == EEARH_ADDR) eearh <= bus_in;
            if (wr && addr == EEARL_ADDR) eearl <= bus_in;
            if (wr && addr == EEDR_ADDR)  eedr  <= bus_in;
            if (wr_eecr) eepm <= eepm_t'(bus_in[EEPM_LSB +: 2]);
         end
         if (wr_eecr) eerie <= bus_in[EERIE_BIT];

         if (start)                             mpe_cnt <= '0;
         else if (wr_eecr && bus_in[EEMPE_BIT]) mpe_cnt <= MW'(MPE_WINDOW);
         else if (mpe_armed)                    mpe_cnt <= mpe_cnt - MW'(1);

         // CPU read: one clock to present the address, one to capture the data.
         if (eere) begin
            if (cpu_rd_phase) begin
               eedr         <= ram_rdata;
               eere         <= 1'b0;
               cpu_rd_phase <= 1'b0;
            end else begin
               cpu_rd_phase <= 1'b1;
            end
         end else if (wr_eecr && bus_in[EERE_BIT] && !busy_q && !start) begin
            eere <= 1'b1;
         end

         ext_rd_q <= ext_active && !eere && ext_eep_data_rd;
         eepe_rsv <= 1'b0;

         case (state)
            ST_IDLE: begin
               if (start) begin
                  prog_addr <= eear[AW-1:0];
                  prog_data <= eedr;
                  prog_mode <= eepm_t'(bus_in[EEPM_LSB +: 2]);
                  cnt       <= CW'(PROG_CYCLES - 1);
                  case (eepm_t'(bus_in[EEPM_LSB +: 2]))
                     EEPM_WRITE_ONLY: begin
                        state  <= ST_WRITE;
                        busy_q <= 1'b1;
                     end
                     EEPM_RESERVED: eepe_rsv <= 1'b1;
                     default: begin
                        state  <= ST_ERASE;
                        busy_q <= 1'b1;
                     end
                  endcase
               end
            end
            ST_ERASE: begin
               if (cnt != '0) begin
                  cnt <= cnt - CW'(1);
               end else if (prog_mode == EEPM_ERASE_ONLY) begin
                  state  <= ST_IDLE;
                  busy_q <= 1'b0;
               end else begin
                  state <= ST_WRITE;
                  cnt   <= CW'(PROG_CYCLES - 1);
               end
            end
            ST_WRITE: begin
               if (cnt != '0) begin
                  cnt <= cnt - CW'(1);
               end else begin
                  state  <= ST_IDLE;
                  busy_q <= 1'b0;
               end
            end
            default: begin
               state  <= ST_IDLE;
               busy_q <= 1'b0;
            end
         endcase

         if (last_clk)     rdy_flag <= 1'b1;
         else if (int_rst) rdy_flag <= 1'b0;
         if (ram_we) modified <= 1'b1;
      end
   end

endmodule

// File: tb/tb_atmega_eep_prog.sv
// Directed bench for atmega_eep_prog: each scenario task drives the bus or
// programmer port and compares against hand-computed values.
module tb_atmega_eep_prog;
   import atmega_eep_pkg::*;

   localparam logic [7:0] A_EEARH = 8'h20;
   localparam logic [7:0] A_EEARL = 8'h21;
   localparam logic [7:0] A_EEDR  = 8'h22;
   localparam logic [7:0] A_EECR  = 8'h23;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  addr = 8'h00;
   logic        wr = 1'b0, rd = 1'b0;
   logic [7:0]  bus_in = 8'h00, bus_out;
   logic        eep_int, int_rst = 1'b0;
   logic [16:0] ext_eep_addr = '0;
   logic [7:0]  ext_eep_data_in = 8'h00, ext_eep_data_out;
   logic        ext_eep_data_wr = 1'b0, ext_eep_data_rd = 1'b0, ext_eep_data_en = 1'b0;
   logic        busy, content_modifyed;
   eep_state_t  state_dbg;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   atmega_eep_prog dut (
      .clk              (clk),
      .rst              (rst),
      .addr             (addr),
      .wr               (wr),
      .rd               (rd),
      .bus_in           (bus_in),
      .bus_out          (bus_out),
      .eep_int          (eep_int),
      .int_rst          (int_rst),
      .ext_eep_addr     (ext_eep_addr),
      .ext_eep_data_in  (ext_eep_data_in),
      .ext_eep_data_wr  (ext_eep_data_wr),
      .ext_eep_data_out (ext_eep_data_out),
      .ext_eep_data_rd  (ext_eep_data_rd),
      .ext_eep_data_en  (ext_eep_data_en),
      .busy             (busy),
      .content_modifyed (content_modifyed),
      .state_dbg        (state_dbg)
   );

   // ---------------- driver tasks (called at a negedge) ----------------
   task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
      addr = a; bus_in = d; wr = 1'b1;
      @(negedge clk);
      wr = 1'b0;
   endtask

   task automatic bus_read(input logic [7:0] a, output logic [7:0] d);
      addr = a; rd = 1'b1;
      #1;
      d = bus_out;
      rd = 1'b0;
   endtask

   task automatic ext_write(input logic [16:0] a, input logic [7:0] d);
      ext_eep_data_en = 1'b1; ext_eep_addr = a; ext_eep_data_in = d; ext_eep_data_wr = 1'b1;
      @(negedge clk);
      ext_eep_data_wr = 1'b0; ext_eep_data_en = 1'b0;
   endtask

   task automatic ext_read(input logic [16:0] a, output logic [7:0] d);
      ext_eep_data_en = 1'b1; ext_eep_addr = a; ext_eep_data_rd = 1'b1;
      @(negedge clk);
      ext_eep_data_rd = 1'b0;
      d = ext_eep_data_out;
      ext_eep_data_en = 1'b0;
   endtask

   // Arm the master-program window, then set EEPE on the next clock.
   task automatic start_prog(input logic [7:0] bits);
      bus_write(A_EECR, bits | 8'h04);
      bus_write(A_EECR, bits | 8'h06);
   endtask

   task automatic count_busy(output int n);
      n = 0;
      while (busy === 1'b1 && n < 200) begin
         n++;
         @(negedge clk);
      end
   endtask

   task automatic cpu_read_array(input logic [15:0] a, input logic [7:0] keep, output logic [7:0] d);
      bus_write(A_EEARH, a[15:8]);
      bus_write(A_EEARL, a[7:0]);
      bus_write(A_EECR, keep | 8'h01);
      @(negedge clk);
      @(negedge clk);
      bus_read(A_EEDR, d);
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      logic [7:0] d;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
      n_cmp++; if (eep_int !== 1'b0) begin n_err++; $display("FAIL reset_int: got %b want 0", eep_int); end
      n_cmp++; if (content_modifyed !== 1'b0) begin n_err++; $display("FAIL reset_modified: got %b want 0", content_modifyed); end
      n_cmp++; if (state_dbg !== ST_IDLE) begin n_err++; $display("FAIL reset_state: got %0d want %0d", state_dbg, ST_IDLE); end
      n_cmp++; if (ext_eep_data_out !== 8'h00) begin n_err++; $display("FAIL reset_ext_out: got %h want 00", ext_eep_data_out); end
      n_cmp++; if (bus_out !== 8'h00) begin n_err++; $display("FAIL idle_bus_out: got %h want 00", bus_out); end
      bus_read(A_EECR, d);
      n_cmp++; if (d !== 8'h00) begin n_err++; $display("FAIL reset_eecr: got %h want 00", d); end
      bus_read(A_EEDR, d);
      n_cmp++; if (d !== 8'h00) begin n_err++; $display("FAIL reset_eedr: got %h want 00", d); end
      cpu_read_array(16'h0005, 8'h00, d);
      n_cmp++; if (d !== 8'hFF) begin n_err++; $display("FAIL powerup_ff: got %h want ff", d); end
   endtask

   task automatic test_erase_write();
      logic [7:0] d;
      int n;
      bus_write(A_EEARH, 8'h00);
      bus_write(A_EEARL, 8'h05);
      bus_write(A_EEDR, 8'hA5);
      start_prog(8'h08);
      n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL ew_busy_start: got %b want 1", busy); end
      bus_read(A_EECR, d);
      n_cmp++; if (d !== 8'h0A) begin n_err++; $display("FAIL ew_eecr_busy: got %h want 0a", d); end
      count_busy(n);
      n_cmp++; if (n != 32) begin n_err++; $display("FAIL ew_busy_len: got %0d want 32", n); end
      n_cmp++; if (eep_int !== 1'b1) begin n_err++; $display("FAIL ew_int: got %b want 1", eep_int); end
      n_cmp++; if (content_modifyed !== 1'b1) begin n_err++; $display("FAIL ew_modified: got %b want 1", content_modifyed); end
      bus_read(A_EECR, d);
      n_cmp++; if (d !== 8'h08) begin n_err++; $display("FAIL ew_eecr_done: got %h want 08", d); end
      cpu_read_array(16'h0005, 8'h08, d);
      n_cmp++; if (d !== 8'hA5) begin n_err++; $display("FAIL ew_data: got %h want a5", d); end
      bus_read(A_EECR, d);
      n_cmp++; if (d !== 8'h08) begin n_err++; $display("FAIL eere_selfclear: got %h want 08", d); end
      int_rst = 1'b1;
      @(negedge clk);
      int_rst = 1'b0;
      n_cmp++; if (eep_int !== 1'b0) begin n_err++; $display("FAIL ew_int_ack: got %b want 0", eep_int); end
   endtask

   task automatic test_no_start();
      logic [7:0] d;
      int n;
      bus_write(A_EEDR, 8'h11);
      bus_write(A_EECR, 8'h04);
      repeat (5) @(negedge clk);
      bus_write(A_EECR, 8'h02);
      count_busy(n);
      n_cmp++; if (n != 0) begin n_err++; $display("FAIL late_eepe_busy: got %0d want 0", n); end
      bus_read(A_EECR, d);
      n_cmp++; if (d !== 8'h00) begin n_err++; $display("FAIL late_eepe_eecr: got %h want 00", d); end
      cpu_read_array(16'h0005, 8'h00, d);
      n_cmp++; if (d !== 8'hA5) begin n_err++; $display("FAIL late_eepe_array: got %h want a5", d); end
   endtask

   task automatic test_write_only_erase_only();
      logic [7:0] d;
      int n;
      ext_write(17'd7, 8'hF0);
      bus_write(A_EEARH, 8'h00);
      bus_write(A_EEARL, 8'h07);
      bus_write(A_EEDR, 8'h3C);
      start_prog(8'h20);
      count_busy(n);
      n_cmp++; if (n != 16) begin n_err++; $display("FAIL wo_busy_len: got %0d want 16", n); end
      ext_read(17'd7, d);
      n_cmp++; if (d !== 8'h30) begin n_err++; $display("FAIL wo_data: got %h want 30", d); end
      @(negedge clk);
      n_cmp++; if (ext_eep_data_out !== 8'h00) begin n_err++; $display("FAIL ext_out_idle: got %h want 00", ext_eep_data_out); end
      start_prog(8'h10);
      count_busy(n);
      n_cmp++; if (n != 16) begin n_err++; $display("FAIL eo_busy_len: got %0d want 16", n); end
      cpu_read_array(16'h0007, 8'h00, d);
      n_cmp++; if (d !== 8'hFF) begin n_err++; $display("FAIL eo_data: got %h want ff", d); end
   endtask

   task automatic test_reset_abort();
      logic [7:0] d;
      ext_write(17'd9, 8'h11);
      bus_write(A_EEARH, 8'h00);
      bus_write(A_EEARL, 8'h09);
      bus_write(A_EEDR, 8'h77);
      start_prog(8'h00);
      repeat (9) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL abort_busy: got %b want 0", busy); end
      n_cmp++; if (state_dbg !== ST_IDLE) begin n_err++; $display("FAIL abort_state: got %0d want %0d", state_dbg, ST_IDLE); end
      n_cmp++; if (content_modifyed !== 1'b0) begin n_err++; $display("FAIL abort_modified: got %b want 0", content_modifyed); end
      bus_read(A_EECR, d);
      n_cmp++; if (d !== 8'h00) begin n_err++; $display("FAIL abort_eecr: got %h want 00", d); end
      bus_read(A_EEARL, d);
      n_cmp++; if (d !== 8'h00) begin n_err++; $display("FAIL abort_eearl: got %h want 00", d); end
      repeat (40) @(negedge clk);
      ext_read(17'd9, d);
      n_cmp++; if (d !== 8'h11) begin n_err++; $display("FAIL abort_array: got %h want 11", d); end
   endtask

   task automatic test_addr_wrap_busy_ignore();
      logic [7:0] d;
      int n;
      bus_write(A_EEARH, 8'h04);
      bus_write(A_EEARL, 8'h05);
      bus_write(A_EEDR, 8'h5A);
      start_prog(8'h00);
      bus_write(A_EEDR, 8'hFF);
      bus_write(A_EEARL, 8'h00);
      ext_write(17'd5, 8'h00);
      bus_read(A_EEARL, d);
      n_cmp++; if (d !== 8'h05) begin n_err++; $display("FAIL busy_eearl_locked: got %h want 05", d); end
      count_busy(n);
      n_cmp++; if (n != 29) begin n_err++; $display("FAIL wrap_busy_len: got %0d want 29", n); end
      bus_read(A_EEARH, d);
      n_cmp++; if (d !== 8'h04) begin n_err++; $display("FAIL wrap_eearh: got %h want 04", d); end
      ext_read(17'd5, d);
      n_cmp++; if (d !== 8'h5A) begin n_err++; $display("FAIL wrap_data: got %h want 5a", d); end
      ext_read(17'h00405, d);
      n_cmp++; if (d !== 8'h5A) begin n_err++; $display("FAIL ext_addr_wrap: got %h want 5a", d); end
   endtask

   task automatic test_int_same_clock();
      int_rst = 1'b1;
      @(negedge clk);
      int_rst = 1'b0;
      start_prog(8'h08);
      repeat (31) @(negedge clk);
      n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL irq_last_busy: got %b want 1", busy); end
      n_cmp++; if (eep_int !== 1'b0) begin n_err++; $display("FAIL irq_before_done: got %b want 0", eep_int); end
      int_rst = 1'b1;
      @(negedge clk);
      n_cmp++; if (eep_int !== 1'b1) begin n_err++; $display("FAIL irq_set_wins: got %b want 1", eep_int); end
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL irq_busy_done: got %b want 0", busy); end
      @(negedge clk);
      int_rst = 1'b0;
      n_cmp++; if (eep_int !== 1'b0) begin n_err++; $display("FAIL irq_ack: got %b want 0", eep_int); end
   endtask

   task automatic test_reserved_mode();
      logic [7:0] d;
      bus_write(A_EEDR, 8'h00);
      start_prog(8'h38);
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rsv_busy: got %b want 0", busy); end
      bus_read(A_EECR, d);
      n_cmp++; if (d !== 8'h3A) begin n_err++; $display("FAIL rsv_eepe_set: got %h want 3a", d); end
      @(negedge clk);
      bus_read(A_EECR, d);
      n_cmp++; if (d !== 8'h38) begin n_err++; $display("FAIL rsv_eepe_clear: got %h want 38", d); end
      repeat (20) @(negedge clk);
      n_cmp++; if (eep_int !== 1'b0) begin n_err++; $display("FAIL rsv_int: got %b want 0", eep_int); end
      ext_read(17'd5, d);
      n_cmp++; if (d !== 8'h5A) begin n_err++; $display("FAIL rsv_array: got %h want 5a", d); end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_erase_write();
      test_no_start();
      test_write_only_erase_only();
      test_reset_abort();
      test_addr_wrap_busy_ignore();
      test_int_same_clock();
      test_reserved_mode();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
